// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, start-glitch rejection, parity/framing flags.
// Word appears one cycle after the last stop decision; a full holding register drops the new frame and pulses overrun.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int M  = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(M);
   localparam logic [CW-1:0] CNT_MID  = CW'(M + 1);
   localparam logic [3:0]    IDX_DLAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    IDX_SLAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_d;
   logic [1:0]           sync;
   logic                 rx_s;
   logic [CW-1:0]        cnt, cnt_d;
   logic [3:0]           idx, idx_d;
   logic [1:0]           samp;
   logic                 maj;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr, done_q;
   logic                 shift_en, par_chk, stop_chk, frame_done, frame_start;

   assign rx_s = sync[1];
   assign maj  = (samp[0] & samp[1]) | (rx_s & (samp[0] | samp[1]));
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d     = state;
      cnt_d       = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      idx_d       = idx;
      shift_en    = 1'b0;
      par_chk     = 1'b0;
      stop_chk    = 1'b0;
      frame_done  = 1'b0;
      frame_start = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d     = START;
               frame_start = 1'b1;
            end
         end
         START: begin
            // A start bit that votes high at mid-bit was line noise
            if (cnt == CNT_MID && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            shift_en = (cnt == CNT_MID);
            if (cnt == CNT_LAST) begin
               if (idx == IDX_DLAST) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx + 1'b1;
               end
            end
         end
         PARITY: begin
            par_chk = (cnt == CNT_MID);
            if (cnt == CNT_LAST) state_d = STOP;
         end
         STOP: begin
            stop_chk = (cnt == CNT_MID);
            // Leave at mid of the last stop bit so a back-to-back start edge is not missed
            if (stop_chk && idx == IDX_SLAST) begin
               state_d    = IDLE;
               cnt_d      = '0;
               frame_done = 1'b1;
            end else if (cnt == CNT_LAST) begin
               idx_d = idx + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= 2'b11;
         cnt    <= '0;
         idx    <= '0;
         samp   <= 2'b11;
         shreg  <= '0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sync   <= {sync[0], data_in};
         cnt    <= cnt_d;
         idx    <= idx_d;
         done_q <= frame_done;
         if (cnt == CNT_S0) samp[0] <= rx_s;
         if (cnt == CNT_S1) samp[1] <= rx_s;
         if (frame_start) begin
            perr <= 1'b0;
            ferr <= 1'b0;
         end
         if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
         if (par_chk) perr <= maj ^ (^shreg) ^ PARITY_ODD[0];
         if (stop_chk && !maj) ferr <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done_q) begin
            if (!data_valid || data_ready) begin
               data_out   <= shreg;
               parity_err <= perr;
               frame_err  <= ferr;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end
endmodule
